// File: rtl/alu_mc_unit.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/compare ops plus an iterative
// shift-add multiplier, with a valid/ready handshake on both sides.
module alu_mc_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_MUL  = 6'b011000;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_NAND = 6'b101000;
    localparam logic [5:0] F_SHL  = 6'b000000;
    localparam logic [5:0] F_SHR  = 6'b000010;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SEQ  = 6'b101011;
    localparam logic [5:0] F_SNE  = 6'b101100;
    localparam logic [5:0] F_SGT  = 6'b101101;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0] op_res;
    logic             op_ill;
    logic [WIDTH-1:0] acc_sum;

    always_comb begin
        op_res = '0;
        op_ill = 1'b0;
        unique case (alu_op)
            2'b00: op_res = a + b;
            2'b01: op_res = a - b;
            2'b11: op_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            default: begin
                case (funct)
                    F_ADD:  op_res = a + b;
                    F_SUB:  op_res = a - b;
                    F_AND:  op_res = a & b;
                    F_OR:   op_res = a | b;
                    F_NOR:  op_res = ~(a | b);
                    F_NAND: op_res = ~(a & b);
                    F_SHL:  op_res = a << b[SHW-1:0];
                    F_SHR:  op_res = a >> b[SHW-1:0];
                    F_SLT:  op_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
                    F_SEQ:  op_res = {{(WIDTH-1){1'b0}}, a == b};
                    F_SNE:  op_res = {{(WIDTH-1){1'b0}}, a != b};
                    F_SGT:  op_res = {{(WIDTH-1){1'b0}}, $signed(a) > $signed(b)};
                    default: op_ill = 1'b1;
                endcase
            end
        endcase
    end

    // Multiplier consumes one bit of b per cycle; the last iteration writes the result directly.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        acc_sum   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (alu_op == 2'b10 && funct == F_MUL) begin
                        acc_d    = '0;
                        mcand_d  = a;
                        mplier_d = b;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else begin
                        result_d  = op_res;
                        zero_d    = (op_res == '0);
                        illegal_d = op_ill;
                        state_d   = DONE;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    result_d  = acc_sum;
                    zero_d    = (acc_sum == '0);
                    illegal_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_mc_unit.sv
// Self-checking bench for alu_mc_unit: directed vector table, hand-written
// multi-cycle sequences and randomized ops against a behavioural model.
module tb_alu_mc_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic ready_hold = 1'b0;

    alu_mc_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .illegal(illegal), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  f;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] res;
        logic        ill;
    } vec_t;

    vec_t vecs[18];
    logic [5:0] legal_f[13];

    task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: returns {illegal, result} straight from the operation definitions.
    function automatic logic [32:0] model(input logic [1:0] op, input logic [5:0] f,
                                          input logic [31:0] x, input logic [31:0] y);
        logic [63:0] prod;
        case (op)
            2'b00: return {1'b0, x + y};
            2'b01: return {1'b0, x - y};
            2'b11: return {1'b0, 31'd0, ($signed(x) < $signed(y))};
            default: begin
                case (f)
                    6'b100000: return {1'b0, x + y};
                    6'b100010: return {1'b0, x - y};
                    6'b011000: begin prod = 64'(x) * 64'(y); return {1'b0, prod[31:0]}; end
                    6'b100100: return {1'b0, x & y};
                    6'b100101: return {1'b0, x | y};
                    6'b100111: return {1'b0, ~(x | y)};
                    6'b101000: return {1'b0, ~(x & y)};
                    6'b000000: return {1'b0, x << y[4:0]};
                    6'b000010: return {1'b0, x >> y[4:0]};
                    6'b101010: return {1'b0, 31'd0, ($signed(x) < $signed(y))};
                    6'b101011: return {1'b0, 31'd0, (x == y)};
                    6'b101100: return {1'b0, 31'd0, (x != y)};
                    6'b101101: return {1'b0, 31'd0, ($signed(x) > $signed(y))};
                    default:   return {1'b1, 32'd0};
                endcase
            end
        endcase
    endfunction

    function automatic int exp_latency(input logic [1:0] op, input logic [5:0] f);
        return (op == 2'b10 && f == 6'b011000) ? 33 : 1;
    endfunction

    // Drive a request from IDLE; returns one step after the accepting edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [5:0] f,
                                 input logic [31:0] va, input logic [31:0] vb);
        checkValue("ready_before_accept", in_ready, 1);
        alu_op   = op;
        funct    = f;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
    endtask

    // Wait for the result with junk requests on the input, check it, then consume it.
    task automatic checkOutput(input string name, input logic [31:0] exp_res,
                               input logic exp_ill, input int exp_lat);
        int lat  = 1;
        int viol = 0;
        while (!out_valid && lat < 100) begin
            if (!busy || in_ready) viol++;
            in_valid = 1'($urandom_range(0, 1));
            alu_op   = 2'($urandom);
            funct    = 6'($urandom);
            a        = $urandom;
            b        = $urandom;
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        checkValue({name, "_out_valid"}, out_valid, 1);
        checkValue({name, "_latency"}, lat, exp_lat);
        checkValue({name, "_busy_wait"}, viol, 0);
        checkValue({name, "_result"}, result, exp_res);
        checkValue({name, "_zero"}, zero, (exp_res == 32'd0));
        checkValue({name, "_illegal"}, illegal, exp_ill);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = ready_hold;
        checkValue({name, "_back_idle"}, {in_ready, out_valid, busy}, 3'b100);
    endtask

    initial begin
        logic [32:0] m;
        logic [1:0]  rop;
        logic [5:0]  rf;
        logic [31:0] ra, rb;

        legal_f = '{6'b100000, 6'b100010, 6'b011000, 6'b100100, 6'b100101, 6'b100111,
                    6'b101000, 6'b000000, 6'b000010, 6'b101010, 6'b101011, 6'b101100, 6'b101101};
        vecs[0]  = '{2'b00, 6'h00,      32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
        vecs[1]  = '{2'b01, 6'h3F,      32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0};
        vecs[2]  = '{2'b11, 6'h00,      32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
        vecs[3]  = '{2'b10, 6'b011000, 32'h00010003, 32'h00000005, 32'h0005000F, 1'b0};
        vecs[4]  = '{2'b10, 6'b101101, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0};
        vecs[5]  = '{2'b10, 6'b101010, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        vecs[6]  = '{2'b10, 6'b000010, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0};
        vecs[7]  = '{2'b10, 6'b111111, 32'h80000000, 32'h00000024, 32'h00000000, 1'b1};
        vecs[8]  = '{2'b10, 6'b000000, 32'h00000001, 32'hFFFFFFE3, 32'h00000008, 1'b0};
        vecs[9]  = '{2'b10, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
        vecs[10] = '{2'b10, 6'b100101, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0};
        vecs[11] = '{2'b10, 6'b100111, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0};
        vecs[12] = '{2'b10, 6'b101000, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 1'b0};
        vecs[13] = '{2'b10, 6'b101011, 32'h00001234, 32'h00001234, 32'h00000001, 1'b0};
        vecs[14] = '{2'b10, 6'b101100, 32'h00001234, 32'h00001234, 32'h00000000, 1'b0};
        vecs[15] = '{2'b10, 6'b100010, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0};
        vecs[16] = '{2'b10, 6'b100000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
        vecs[17] = '{2'b10, 6'b011000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = 2'b00; funct = 6'd0; a = 32'd0; b = 32'd0;
        #12;
        checkValue("reset_state", {in_ready, out_valid, busy, zero, illegal, result},
                   {5'b10000, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed vectors");
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].op, vecs[i].f, vecs[i].va, vecs[i].vb);
            checkOutput($sformatf("vec%0d", i), vecs[i].res, vecs[i].ill,
                        exp_latency(vecs[i].op, vecs[i].f));
        end

        $display("[TB] DONE hold with out_ready low");
        applyStimulus(2'b00, 6'd0, 32'd10, 32'd20);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            alu_op   = 2'b01;
            a        = $urandom;
            b        = $urandom;
            @(posedge clk);
            #1;
            checkValue($sformatf("hold%0d", i), {out_valid, in_ready, result}, {2'b10, 32'd30});
        end
        in_valid = 1'b0;
        checkOutput("hold_end", 32'd30, 1'b0, 1);
        @(posedge clk);
        #1;
        checkValue("hold_no_stray_accept", {out_valid, busy}, 2'b00);

        $display("[TB] reset mid-multiply");
        applyStimulus(2'b10, 6'b011000, 32'h00010003, 32'h00000005);
        repeat (9) @(posedge clk);
        #1;
        checkValue("mid_mul_busy", {busy, in_ready}, 2'b10);
        rst_n = 1'b0;
        #1;
        checkValue("async_reset", {in_ready, out_valid, busy, zero, illegal, result},
                   {5'b10000, 32'd0});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(2'b00, 6'd0, 32'd2, 32'd3);
        checkOutput("post_reset_add", 32'd5, 1'b0, 1);

        $display("[TB] randomized ops");
        for (int i = 0; i < 60; i++) begin
            rop = 2'($urandom);
            rf  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_f[$urandom_range(0, 12)];
            ra  = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? ra : $urandom;
            ready_hold = 1'($urandom_range(0, 1));
            out_ready  = ready_hold;
            m = model(rop, rf, ra, rb);
            applyStimulus(rop, rf, ra, rb);
            checkOutput($sformatf("rand%0d", i), m[31:0], m[32], exp_latency(rop, rf));
        end
        out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mc_unit.md
ALU_MC_UNIT -- requirements
Module: alu_mc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal 8..64, power of two).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), meaning shift-amount width taken from b[SHW-1:0].
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operation request valid.
REQ-007 in_ready  output  1  unit can accept a request.
REQ-008 alu_op  input  2  operation class: 00 add, 01 sub, 10 funct-decoded, 11 slt.
REQ-009 funct  input  6  R-type function code, used only when alu_op=10.
REQ-010 a  input  WIDTH  operand A.
REQ-011 b  input  WIDTH  operand B.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 result  output  WIDTH  registered result.
REQ-015 zero  output  1  result == 0.
REQ-016 illegal  output  1  undefined funct was decoded for this result.
REQ-017 busy  output  1  state != IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, MUL, DONE; in_ready=1 only in IDLE.
REQ-019 Accept = in_valid & in_ready at a rising edge; a, b, alu_op and funct are captured at accept and are ignored at all other times.
REQ-020 Single-cycle ops: IDLE -> DONE on accept; result, zero and illegal are registered, and out_valid=1 on the next cycle (latency 1).
REQ-021 MUL (alu_op=10, funct=011000): IDLE -> MUL; iterative shift-add, 1 multiplier bit per cycle, WIDTH cycles in MUL, then DONE; result = low WIDTH bits of a*b (unsigned; equal to signed low half).
REQ-022 DONE holds result, zero, illegal and out_valid=1 stable until out_ready=1; DONE & out_ready -> IDLE next edge; no back-to-back accept in the same cycle.
REQ-023 Decode for alu_op=10: 100000 add; 100010 sub; 011000 mul; 100100 and; 100101 or; 100111 nor; 101000 nand; 000000 shl (a << b[SHW-1:0]); 000010 shr logical; 101010 slt; 101011 seq; 101100 sne; 101101 sgt.
REQ-024 add/sub wrap modulo 2^WIDTH with no overflow flag.
REQ-025 slt/sgt compare a and b as signed two's complement; seq/sne compare all WIDTH bits.
REQ-026 Set-condition ops yield result = {WIDTH-1 zeros, flag}.
REQ-027 Shift amount uses only b[SHW-1:0]; upper bits of b are ignored; shr fills with zeros.
REQ-028 Undefined funct: result=0, zero=1, illegal=1, latency 1.
REQ-029 illegal=0 for every defined operation.
REQ-030 in_valid asserted in MUL or DONE is not accepted and produces no side effect.
REQ-031 out_ready while not in DONE is ignored.

Reset
REQ-032 rst_n=0 SHALL asynchronously force IDLE, in_ready=1, out_valid=0, busy=0, result=0, zero=0, illegal=0, and clear the multiplier accumulator and counter.
REQ-033 Reset during MUL or DONE SHALL abort the operation and discard its result; the first accept after reset release behaves as from cold start.

Verification
REQ-034 WIDTH=32, alu_op=00, a=0xFFFFFFFF, b=1 -> one cycle after accept: out_valid=1, result=0, zero=1, illegal=0.
REQ-035 alu_op=10, funct=011000, a=0x0001_0003, b=0x0000_0005 -> busy for 32 MUL cycles, then result=0x0005_000F; in_ready=0 throughout.
REQ-036 alu_op=10, funct=101101, a=0x00000001, b=0xFFFFFFFF -> result=1; funct=101010 with the same operands -> result=0.
REQ-037 funct=000010, a=0x80000000, b=0x00000024 -> result=0x08000000 (shift 4); funct=111111 -> result=0, illegal=1.
REQ-038 Hold out_ready=0 for 5 cycles in DONE -> result stable and out_valid=1 throughout; a new in_valid in that window is not accepted.
REQ-039 rst_n pulsed low mid-MUL (cycle 10) -> outputs take reset values immediately; next accepted add completes in 1 cycle with the correct result.
